// File: rtl/aes_inv_mixcol_seq.sv
// Iterative AES InvMixColumns: one 32-bit column per clock through a single XOR/xtime engine,
// result held in an output register until the consumer takes it; bypass skips the transform.
module aes_inv_mixcol_seq #(
    parameter int NCOL  = 4,
    parameter int COL_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NCOL*COL_W-1:0]   in_state,
    input  logic                    bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NCOL*COL_W-1:0]   out_state,
    output logic                    busy
);

    localparam int STATE_W = NCOL * COL_W;
    localparam int CNT_W   = $clog2(NCOL);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(NCOL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               fsm, fsm_nxt;
    logic [CNT_W-1:0]   col_cnt, col_cnt_nxt;
    logic [STATE_W-1:0] work_p0;
    logic [STATE_W-1:0] work_upd;
    logic [COL_W-1:0]   col_in;
    logic [COL_W-1:0]   col_out;
    logic               accept;
    logic               last_col;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // 09/0B/0D/0E products are assembled from x, 2x, 4x, 8x so only XOR and xtime are used.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m09[4];
        logic [7:0] m0b[4];
        logic [7:0] m0d[4];
        logic [7:0] m0e[4];
        logic [7:0] x2, x4, x8;
        logic [7:0] b  [4];
        for (int k = 0; k < 4; k++) begin
            a[k]   = col[31-8*k -: 8];
            x2     = xtime(a[k]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m09[k] = x8 ^ a[k];
            m0b[k] = x8 ^ x2 ^ a[k];
            m0d[k] = x8 ^ x4 ^ a[k];
            m0e[k] = x8 ^ x4 ^ x2;
        end
        b[0] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
        b[1] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
        b[2] = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
        b[3] = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];
        return {b[0], b[1], b[2], b[3]};
    endfunction

    assign accept   = (fsm == IDLE) && in_valid;
    assign last_col = (col_cnt == LAST_COL);

    always_comb begin
        col_in = work_p0[STATE_W-1 -: COL_W];
        for (int c = 0; c < NCOL; c++) begin
            if (col_cnt == CNT_W'(c)) begin
                col_in = work_p0[STATE_W-1-COL_W*c -: COL_W];
            end
        end
    end

    assign col_out = inv_mix_col(col_in);

    always_comb begin
        work_upd = work_p0;
        for (int c = 0; c < NCOL; c++) begin
            if (col_cnt == CNT_W'(c)) begin
                work_upd[STATE_W-1-COL_W*c -: COL_W] = col_out;
            end
        end
    end

    always_comb begin
        fsm_nxt     = fsm;
        col_cnt_nxt = col_cnt;
        if (clr) begin
            fsm_nxt     = IDLE;
            col_cnt_nxt = '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        col_cnt_nxt = '0;
                        fsm_nxt     = bypass ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (last_col) begin
                        col_cnt_nxt = '0;
                        fsm_nxt     = DONE;
                    end else begin
                        col_cnt_nxt = col_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_nxt = IDLE;
                    end
                end
                default: begin
                    fsm_nxt     = IDLE;
                    col_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Stage p0: working state captured on accept, one column rewritten per BUSY edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm     <= IDLE;
            col_cnt <= '0;
            work_p0 <= '0;
        end else begin
            fsm     <= fsm_nxt;
            col_cnt <= col_cnt_nxt;
            if (!clr) begin
                if (accept) begin
                    work_p0 <= in_state;
                end else if (fsm == BUSY) begin
                    work_p0 <= work_upd;
                end
            end
        end
    end

    // Output register is only loaded with a complete result, so partial columns never show.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state <= '0;
        end else if (!clr) begin
            if (accept && bypass) begin
                out_state <= in_state;
            end else if (fsm == BUSY && last_col) begin
                out_state <= work_upd;
            end
        end
    end

    assign in_ready  = (fsm == IDLE);
    assign out_valid = (fsm == DONE);
    assign busy      = (fsm == BUSY) || (fsm == DONE);

endmodule

// File: tb/tb_aes_inv_mixcol_seq.sv
// Directed bench for aes_inv_mixcol_seq: known InvMixColumns vectors, handshake timing,
// reset/clear aborts and back-to-back throughput against a GF(2^8) reference.
module tb_aes_inv_mixcol_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    aes_inv_mixcol_seq #(.NCOL(4), .COL_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .bypass    (bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix_ref(input logic [127:0] s);
        logic [7:0]   m[4];
        logic [7:0]   a[4];
        logic [7:0]   acc;
        logic [127:0] r;
        m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(a[k], m[(k - row + 4) % 4]);
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [127:0] s, input logic byp);
        in_state = s;
        bypass   = byp;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bypass   = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [127:0] s, input logic byp,
                           input logic [127:0] exp, input int exp_lat);
        int n;
        check_val({tag, "_in_ready"}, 128'(in_ready), 128'(1));
        start(s, byp);
        wait_done(n);
        check_val({tag, "_latency"}, 128'(n), 128'(exp_lat));
        check_val({tag, "_out"}, out_state, exp);
        pop();
        check_val({tag, "_valid_drop"}, 128'(out_valid), 128'(0));
    endtask

    localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;
    localparam logic [127:0] V3     = 128'h01234567_89abcdef_fedcba98_76543210;

    initial begin
        logic [127:0] vecs[4];
        int n;
        int idx;
        int nres;
        int last_acc;
        logic acc;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_state = '0;
        bypass = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_val("rst_in_ready",  128'(in_ready),  128'(1));
        check_val("rst_out_valid", 128'(out_valid), 128'(0));
        check_val("rst_busy",      128'(busy),      128'(0));
        check_val("rst_out_state", out_state,       128'(0));

        // Known-answer vectors and bypass.
        run_one("v1", V1_IN, 1'b0, V1_OUT, 4);
        run_one("v2", V2_IN, 1'b0, V2_OUT, 4);
        run_one("byp", V3, 1'b1, V3, 0);

        // Consumer stall with a pending input held the whole time.
        start(V1_IN, 1'b0);
        wait_done(n);
        check_val("hold_latency", 128'(n), 128'(4));
        in_state = V2_IN;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("hold_valid", 128'(out_valid), 128'(1));
            check_val("hold_out",   out_state,       V1_OUT);
            check_val("hold_ready", 128'(in_ready),  128'(0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("hold_release_valid", 128'(out_valid), 128'(0));
        check_val("hold_release_ready", 128'(in_ready),  128'(1));
        tick();
        in_valid = 1'b0;
        check_val("hold_accepted_busy", 128'(busy), 128'(1));
        wait_done(n);
        check_val("hold_next_latency", 128'(n), 128'(4));
        check_val("hold_next_out", out_state, V2_OUT);
        pop();

        // Out_ready pulse with nothing pending is ignored.
        pop();
        check_val("stray_ready_in_ready", 128'(in_ready), 128'(1));

        // Asynchronous reset with col_cnt=2.
        start(V3, 1'b0);
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_out_valid", 128'(out_valid), 128'(0));
        check_val("arst_busy",      128'(busy),      128'(0));
        check_val("arst_out_state", out_state,       128'(0));
        tick();
        rst = 1'b0;
        tick();
        run_one("after_rst", V2_IN, 1'b0, V2_OUT, 4);

        // Synchronous clear in BUSY and in DONE.
        start(V1_IN, 1'b0);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clr_busy_valid", 128'(out_valid), 128'(0));
        check_val("clr_busy_busy",  128'(busy),      128'(0));
        check_val("clr_busy_ready", 128'(in_ready),  128'(1));
        start(V3, 1'b1);
        check_val("clr_done_pre", 128'(out_valid), 128'(1));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_val("clr_done_valid", 128'(out_valid), 128'(0));
        check_val("clr_done_busy",  128'(busy),      128'(0));
        run_one("after_clr", V1_IN, 1'b0, V1_OUT, 4);

        // Back-to-back states with out_ready tied high.
        for (int i = 0; i < 4; i++) vecs[i] = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_state  = vecs[0];
        in_valid  = 1'b1;
        idx = 0; nres = 0; last_acc = -1;
        for (int cyc = 0; cyc < 80 && nres < 4; cyc++) begin
            acc = in_ready && in_valid;
            tick();
            if (acc) begin
                if (last_acc >= 0) check_val("b2b_period", 128'(cyc - last_acc), 128'(6));
                last_acc = cyc;
                idx++;
                if (idx < 4) in_state = vecs[idx];
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                check_val("b2b_out", out_state, inv_mix_ref(vecs[nres]));
                nres++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("b2b_count", 128'(nres), 128'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
